// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_responder_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  // Wait-state counter width and the largest legal wait count it can hold.
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with a registered read port (one-cycle latency).
// Contents are deliberately not reset.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled; the read port always registers the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: latches a read/write request, inserts
// WAIT_STATES wait cycles, performs one RAM access and pulses done.
//
//   state | meaning
//   IDLE  | no operation; a request here is captured
//   WAIT  | counting down wait states, then issuing the RAM access
//   RESP  | access complete; done is high, read data is presented
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done
);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait_states
    $error("dmem_responder: WAIT_STATES must be in 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              req;
  logic              capture;
  logic              issue;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic              unused_addr;

  // Upper address bits are intentionally ignored.
  assign unused_addr = ^addr;

  assign req = mem_rd | mem_wr;

  // Next-state logic; a dropped request aborts only while the access is still pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    issue   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          issue   = 1'b1;
          ram_we  = op_wr_q;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= issue;
    end
  end

  // Request capture; both strobes high is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      op_wr_q <= mem_wr;
      addr_q  <= addr[ADDR_W-1:0];
      wdata_q <= wdata;
    end
  end

  // Hold the last completed read so rdata stays stable after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == RESP && !op_wr_q) begin
      rdata_q <= ram_q;
    end
  end

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // During a read's done cycle the RAM output register is presented directly,
  // so the data is valid alongside done; otherwise the held value is shown.
  assign rdata = (state_q == RESP && !op_wr_q) ? ram_q : rdata_q;
  assign done  = done_q;
  assign stall = req & ~done_q;

endmodule
